// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among N_REQ on-chip requesters. A round-robin
//   arbiter grants one byte at a time. The sequencer then fires a single
//   send/load pulse, waits for the UART to report frame completion, and
//   inserts an inter-frame gap. A watchdog returns the block to IDLE and sets
//   a sticky error if the UART never reports done.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   req_valid         per-requester byte valid (held until its ready pulse)
//   req_data          requester i byte at [i*DATA_W +: DATA_W]
//   req_ready         one-hot, 1-cycle accept pulse to the granted requester
//   uart_tx_data      latched byte; stable from ACCEPT until the next grant
//   uart_tx_send      1-cycle start pulse to the UART TX FSM
//   uart_tx_send_en   load enable, asserted together with uart_tx_send
//   uart_tx_done      1-cycle stop-bit-complete pulse; only honoured in WAIT
//   grant_id          index of the current or last granted requester
//   busy              high in every state except IDLE
//   timeout_err       sticky watchdog-abort flag, cleared by err_clr
//   err_clr           clears timeout_err (a new abort in the same cycle wins)

module uart_tx_arbiter #(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 8192,
   parameter int GAP_CYC     = 2,
   localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic [DATA_W-1:0]         uart_tx_data,
   output logic                      uart_tx_send,
   output logic                      uart_tx_send_en,
   input  logic                      uart_tx_done,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy,
   output logic                      timeout_err,
   input  logic                      err_clr
);

   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   // A zero-cycle gap never enters GAP; keep the counter at least one bit wide.
   localparam int GP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [GP_W-1:0] GP_LAST = (GAP_CYC > 0) ? GP_W'(GAP_CYC - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_SEND,
      S_WAIT,
      S_GAP
   } state_t;

   state_t state, state_nxt;

   logic [N_REQ-1:0][DATA_W-1:0] req_bytes;
   logic [ID_W-1:0]              last_grant;
   logic [ID_W-1:0]              sel_idx;
   logic                         sel_found;
   logic [WD_W-1:0]              wdog;
   logic [GP_W-1:0]              gap_cnt;
   logic                         wd_expire;
   logic                         gap_last;
   logic                         wait_exit;
   logic                         abort;

   assign req_bytes = req_data;
   assign wd_expire = (wdog == WD_LAST);
   assign gap_last  = (gap_cnt == GP_LAST);
   assign wait_exit = (state == S_WAIT) && (uart_tx_done || wd_expire);
   // Done and expiry in the same cycle is a normal completion.
   assign abort     = (state == S_WAIT) && !uart_tx_done && wd_expire;

   // Round-robin search starting one past the last completed grant.
   always_comb begin : arb
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!sel_found && req_valid[(int'(last_grant) + k) % N_REQ]) begin
            sel_found = 1'b1;
            sel_idx   = ID_W'((int'(last_grant) + k) % N_REQ);
         end
      end
   end

   always_ff @(posedge clk) begin : state_reg
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin : next_state
      state_nxt = state;
      case (state)
         S_IDLE:   if (sel_found) state_nxt = S_ACCEPT;
         S_ACCEPT: state_nxt = S_SEND;
         S_SEND:   state_nxt = S_WAIT;
         S_WAIT: begin
            if (uart_tx_done)   state_nxt = (GAP_CYC > 0) ? S_GAP : S_IDLE;
            else if (wd_expire) state_nxt = S_IDLE;
         end
         S_GAP:    if (gap_last) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin : datapath
      if (rst) begin
         last_grant   <= ID_W'(N_REQ - 1);
         grant_id     <= '0;
         uart_tx_data <= '0;
         wdog         <= '0;
         gap_cnt      <= '0;
         timeout_err  <= 1'b0;
      end else begin
         if (state == S_IDLE && sel_found) begin
            grant_id     <= sel_idx;
            uart_tx_data <= req_bytes[sel_idx];
         end

         if (state == S_SEND)      wdog <= '0;
         else if (state == S_WAIT) wdog <= wdog + 1'b1;

         // Rotation only advances once a grant has finished (or been aborted).
         if (wait_exit) last_grant <= grant_id;

         if (state != S_GAP)  gap_cnt <= '0;
         else if (!gap_last)  gap_cnt <= gap_cnt + 1'b1;

         if (abort)        timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;
      end
   end

   // All outputs decode registered state only; req_valid never reaches req_ready.
   for (genvar i = 0; i < N_REQ; i++) begin : g_ready
      assign req_ready[i] = (state == S_ACCEPT) && (grant_id == ID_W'(i));
   end

   assign uart_tx_send    = (state == S_SEND);
   assign uart_tx_send_en = (state == S_SEND);
   assign busy            = (state != S_IDLE);

endmodule
